// File: rtl/sam_sram_pkg.sv
// Shared types for the SAM Coupe SRAM arbiter: FSM encoding, boot config
// address and the layout of the scandoubler config byte.
package sam_sram_pkg;

   typedef enum logic [2:0] {
      BOOT_ADDR   = 3'd0,
      BOOT_LATCH  = 3'd1,
      RUN_CORE    = 3'd2,
      HOST_SETUP  = 3'd3,
      HOST_STROBE = 3'd4,
      HOST_DONE   = 3'd5
   } arb_state_t;

   localparam logic [18:0] CFG_ADDR_DEF = 19'h08FD5;

   typedef struct packed {
      logic [5:0] rsvd;
      logic       scanline_en;
      logic       scandbl_en;
   } cfg_t;

endpackage

// File: rtl/sam_sram_arbiter.sv
// Single-port SRAM arbiter: boots the config byte, then passes the bus to the
// core and slips host accesses into core idle slots (or forces them on starvation).
module sam_sram_arbiter
   import sam_sram_pkg::*;
#(
   parameter int                ADDR_W     = 19,
   parameter logic [ADDR_W-1:0] CFG_ADDR   = ADDR_W'(CFG_ADDR_DEF),
   parameter int                BOOT_WAIT  = 6,
   parameter int                STARVE_LIM = 8
) (
   input  logic              clk24,
   input  logic              reset,
   input  logic              core_req,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic              core_we_n,
   input  logic [7:0]        core_wdata,
   output logic              core_wait,
   output logic              core_reset_n,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [7:0]        host_wdata,
   output logic              host_ack,
   output logic [7:0]        host_rdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_we_n,
   output logic [7:0]        sram_dq_o,
   output logic              sram_dq_oe,
   input  logic [7:0]        sram_dq_i,
   output logic [7:0]        cfg_byte,
   output logic              cfg_valid
);

   localparam logic [5:0] BOOT_LAST = 6'(BOOT_WAIT - 1);
   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIM);

   arb_state_t        state_q, state_d;
   logic [5:0]        boot_cnt_q, boot_cnt_d;
   logic [7:0]        starve_q, starve_d;
   logic [ADDR_W-1:0] h_addr_q, h_addr_d;
   logic              h_we_q, h_we_d;
   logic [7:0]        h_wdata_q, h_wdata_d;
   logic [7:0]        host_rdata_q, host_rdata_d;
   cfg_t              cfg_byte_q, cfg_byte_d;
   logic              cfg_valid_q, cfg_valid_d;
   logic              core_rst_n_q, core_rst_n_d;
   logic              grant;

   always_comb begin
      state_d      = state_q;
      boot_cnt_d   = boot_cnt_q;
      starve_d     = starve_q;
      h_addr_d     = h_addr_q;
      h_we_d       = h_we_q;
      h_wdata_d    = h_wdata_q;
      host_rdata_d = host_rdata_q;
      cfg_byte_d   = cfg_byte_q;
      cfg_valid_d  = cfg_valid_q;
      core_rst_n_d = core_rst_n_q;
      grant        = 1'b0;
      sram_addr    = CFG_ADDR;
      sram_we_n    = 1'b1;
      sram_dq_o    = 8'h00;
      sram_dq_oe   = 1'b0;
      core_wait    = 1'b1;
      host_ack     = 1'b0;

      case (state_q)
         BOOT_ADDR: begin
            if (boot_cnt_q == BOOT_LAST) begin
               boot_cnt_d = 6'd0;
               state_d    = BOOT_LATCH;
            end else begin
               boot_cnt_d = boot_cnt_q + 6'd1;
            end
         end
         BOOT_LATCH: begin
            cfg_byte_d   = cfg_t'(sram_dq_i);
            cfg_valid_d  = 1'b1;
            core_rst_n_d = 1'b1;
            state_d      = RUN_CORE;
         end
         RUN_CORE: begin
            sram_addr  = core_addr;
            sram_we_n  = core_we_n | ~core_req;
            sram_dq_o  = core_wdata;
            sram_dq_oe = core_req & ~core_we_n;
            core_wait  = 1'b0;
            // Core keeps the bus in the grant cycle; the host cycle starts next.
            grant = host_req & (~core_req | (starve_q == STARVE_MAX));
            if (grant) begin
               h_addr_d  = host_addr;
               h_we_d    = host_we;
               h_wdata_d = host_wdata;
               starve_d  = 8'd0;
               state_d   = HOST_SETUP;
            end else if (host_req & core_req) begin
               if (starve_q != STARVE_MAX) starve_d = starve_q + 8'd1;
            end else if (!host_req) begin
               starve_d = 8'd0;
            end
         end
         HOST_SETUP: begin
            sram_addr  = h_addr_q;
            sram_dq_o  = h_wdata_q;
            sram_dq_oe = h_we_q;
            state_d    = HOST_STROBE;
         end
         HOST_STROBE: begin
            sram_addr  = h_addr_q;
            sram_dq_o  = h_wdata_q;
            sram_dq_oe = h_we_q;
            sram_we_n  = ~h_we_q;
            if (!h_we_q) host_rdata_d = sram_dq_i;
            state_d    = HOST_DONE;
         end
         HOST_DONE: begin
            sram_addr  = h_addr_q;
            sram_dq_o  = h_wdata_q;
            sram_dq_oe = h_we_q;
            host_ack   = 1'b1;
            state_d    = RUN_CORE;
         end
         default: state_d = BOOT_ADDR;
      endcase
   end

   always_ff @(posedge clk24) begin
      if (reset) begin
         state_q      <= BOOT_ADDR;
         boot_cnt_q   <= 6'd0;
         starve_q     <= 8'd0;
         h_addr_q     <= '0;
         h_we_q       <= 1'b0;
         h_wdata_q    <= 8'h00;
         host_rdata_q <= 8'h00;
         cfg_byte_q   <= '0;
         cfg_valid_q  <= 1'b0;
         core_rst_n_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         boot_cnt_q   <= boot_cnt_d;
         starve_q     <= starve_d;
         h_addr_q     <= h_addr_d;
         h_we_q       <= h_we_d;
         h_wdata_q    <= h_wdata_d;
         host_rdata_q <= host_rdata_d;
         cfg_byte_q   <= cfg_byte_d;
         cfg_valid_q  <= cfg_valid_d;
         core_rst_n_q <= core_rst_n_d;
      end
   end

   assign host_rdata   = host_rdata_q;
   assign cfg_byte     = cfg_byte_q;
   assign cfg_valid    = cfg_valid_q;
   assign core_reset_n = core_rst_n_q;

endmodule

// File: tb/tb_sam_sram_arbiter.sv
// Directed bench for sam_sram_arbiter against a behavioural 512Kx8 SRAM.
module tb_sam_sram_arbiter;

   localparam int          ADDR_W     = 19;
   localparam logic [18:0] CFG_A      = 19'h08FD5;
   localparam int          BOOT_WAIT  = 6;
   localparam int          STARVE_LIM = 8;

   logic              clk24 = 1'b0;
   logic              reset;
   logic              core_req, core_we_n;
   logic [ADDR_W-1:0] core_addr;
   logic [7:0]        core_wdata;
   logic              core_wait, core_reset_n;
   logic              host_req, host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [7:0]        host_wdata;
   logic              host_ack;
   logic [7:0]        host_rdata;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_we_n, sram_dq_oe;
   logic [7:0]        sram_dq_o, sram_dq_i;
   logic [7:0]        cfg_byte;
   logic              cfg_valid;

   logic [7:0] mem [0:524287];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk24 = ~clk24;

   assign sram_dq_i = mem[sram_addr];

   always @(posedge clk24)
      if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;

   sam_sram_arbiter #(
      .ADDR_W(ADDR_W), .CFG_ADDR(CFG_A), .BOOT_WAIT(BOOT_WAIT), .STARVE_LIM(STARVE_LIM)
   ) dut (
      .clk24(clk24), .reset(reset),
      .core_req(core_req), .core_addr(core_addr), .core_we_n(core_we_n),
      .core_wdata(core_wdata), .core_wait(core_wait), .core_reset_n(core_reset_n),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
      .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_dq_o(sram_dq_o),
      .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
      .cfg_byte(cfg_byte), .cfg_valid(cfg_valid)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk24);
      #1;
   endtask

   // Runs the boot sequence from the current reset edge; returns edges to cfg_valid.
   task automatic wait_boot(output int n, output bit we_seen, output bit ack_seen);
      n = 0; we_seen = 0; ack_seen = 0;
      while (!cfg_valid && n < 50) begin
         tick();
         n++;
         if (!sram_we_n) we_seen = 1;
         if (host_ack) ack_seen = 1;
      end
   endtask

   initial begin
      int  n;
      bit  we_seen, ack_seen;

      reset = 1; core_req = 0; core_we_n = 1; core_addr = '0; core_wdata = 8'h00;
      host_req = 0; host_we = 0; host_addr = '0; host_wdata = 8'h00;
      mem[CFG_A] = 8'h02; mem[19'h7FFFF] = 8'h5C;
      mem[19'h01234] = 8'h00; mem[19'h00ABC] = 8'h00; mem[19'h00100] = 8'h11;

      tick(); tick();
      chk("rst_cfg_valid", cfg_valid, 0);
      chk("rst_core_rst_n", core_reset_n, 0);
      chk("rst_core_wait", core_wait, 1);
      chk("rst_sram_addr", sram_addr, CFG_A);
      chk("rst_we_n", sram_we_n, 1);
      chk("rst_oe", sram_dq_oe, 0);
      chk("rst_dq_o", sram_dq_o, 0);
      chk("rst_ack", host_ack, 0);
      chk("rst_rdata", host_rdata, 0);
      chk("rst_cfg_byte", cfg_byte, 0);

      // Boot read
      reset = 0;
      wait_boot(n, we_seen, ack_seen);
      chk("boot_latency", n, BOOT_WAIT + 1);
      chk("boot_cfg_byte", cfg_byte, 8'h02);
      chk("boot_core_rst_n", core_reset_n, 1);
      chk("boot_we_n_high", we_seen, 0);
      chk("boot_core_wait", core_wait, 0);

      // Host write, core idle: grant in this cycle
      host_req = 1; host_we = 1; host_addr = 19'h01234; host_wdata = 8'hA5;
      #1;
      chk("wr_grant_core_wait", core_wait, 0);
      tick();
      host_addr = 19'h00055; host_wdata = 8'h00;   // ignored after grant
      chk("wr_setup_we_n", sram_we_n, 1);
      chk("wr_setup_addr", sram_addr, 19'h01234);
      chk("wr_setup_oe", sram_dq_oe, 1);
      chk("wr_setup_wait", core_wait, 1);
      chk("wr_setup_ack", host_ack, 0);
      tick();
      chk("wr_strobe_we_n", sram_we_n, 0);
      chk("wr_strobe_addr", sram_addr, 19'h01234);
      chk("wr_strobe_dq", sram_dq_o, 8'hA5);
      chk("wr_strobe_ack", host_ack, 0);
      tick();
      chk("wr_done_we_n", sram_we_n, 1);
      chk("wr_done_ack", host_ack, 1);
      chk("wr_done_oe", sram_dq_oe, 1);
      chk("wr_mem", mem[19'h01234], 8'hA5);
      host_req = 0;
      tick();
      chk("wr_after_ack", host_ack, 0);
      chk("wr_after_wait", core_wait, 0);

      // Host read at top of memory
      host_req = 1; host_we = 0; host_addr = 19'h7FFFF;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk("rd_oe", sram_dq_oe, 0);
         chk("rd_addr", sram_addr, 19'h7FFFF);
         chk("rd_ack", host_ack, (i == 3));
      end
      chk("rd_rdata", host_rdata, 8'h5C);
      host_req = 0;
      tick();

      // Core busy with pending host read: starvation forces a slot
      core_req = 1; core_we_n = 1; core_addr = 19'h00100;
      host_req = 1; host_we = 0; host_addr = 19'h7FFFF;
      #1;
      chk("st_core_addr", sram_addr, 19'h00100);
      tick();
      chk("st_no_grant_wait", core_wait, 0);
      chk("st_no_grant_addr", sram_addr, 19'h00100);
      n = 1;
      while (!core_wait && n < 40) begin
         tick();
         n++;
      end
      chk("st_setup_cycle", n, STARVE_LIM + 1);
      chk("st_host_addr", sram_addr, 19'h7FFFF);
      tick();
      chk("st_strobe_wait", core_wait, 1);
      tick();
      chk("st_done_wait", core_wait, 1);
      chk("st_done_ack", host_ack, 1);
      chk("st_done_rdata", host_rdata, 8'h5C);
      host_req = 0;
      tick();
      chk("st_resume_wait", core_wait, 0);
      chk("st_resume_addr", sram_addr, 19'h00100);
      core_req = 0;
      tick();

      // Reset in HOST_STROBE of a write
      host_req = 1; host_we = 1; host_addr = 19'h00ABC; host_wdata = 8'h3C;
      tick();
      tick();
      chk("ab_strobe_we_n", sram_we_n, 0);
      reset = 1;
      mem[CFG_A] = 8'h03;
      tick();
      chk("ab_we_n", sram_we_n, 1);
      chk("ab_oe", sram_dq_oe, 0);
      chk("ab_ack", host_ack, 0);
      chk("ab_cfg_valid", cfg_valid, 0);
      chk("ab_core_rst_n", core_reset_n, 0);
      chk("ab_addr", sram_addr, CFG_A);
      reset = 0; host_req = 0;
      wait_boot(n, we_seen, ack_seen);
      chk("reboot_latency", n, BOOT_WAIT + 1);
      chk("reboot_cfg_byte", cfg_byte, 8'h03);
      chk("reboot_no_ack", ack_seen, 0);
      chk("reboot_we_n_high", we_seen, 0);

      // Later host write completes normally
      mem[19'h00ABC] = 8'h00;
      host_req = 1; host_we = 1; host_addr = 19'h00ABC; host_wdata = 8'h3C;
      tick(); tick(); tick();
      chk("post_ack", host_ack, 1);
      chk("post_mem", mem[19'h00ABC], 8'h3C);
      host_req = 0;
      tick();
      chk("post_ack_clear", host_ack, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
